// File: rtl/cla_seq_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder:
// FSM encoding, slice width and default operand width.
package cla_seq_pkg;

    localparam int SLICE_W   = 4;
    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_4.sv
// 4-bit carry-lookahead adder slice; all carries are computed directly
// from generate/propagate terms, so there is no ripple chain inside.
module cla_4
    import cla_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_ci,
    output logic [SLICE_W-1:0] o_s,
    output logic               o_co
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    assign w_c[0] = i_ci;
    assign w_c[1] = w_g[0] | (w_p[0] & i_ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_ci);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_ci);

    assign o_s  = w_p ^ w_c[3:0];
    assign o_co = w_c[4];

endmodule

// File: rtl/cla_seq16.sv
// Sequential adder/subtractor: one shared 4-bit CLA slice processes one
// nibble per cycle, LSB first, with the carry held in a register between passes.
module cla_seq16
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NIB   = WIDTH / SLICE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               r_zero;

    logic [SLICE_W-1:0] w_na;
    logic [SLICE_W-1:0] w_nb;
    logic [SLICE_W-1:0] w_s;
    logic               w_co;
    logic [WIDTH-1:0]   w_sum_nxt;
    logic               w_last;
    logic               w_accept;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_cnt == CW'(NIB - 1));

    always_comb begin
        w_na = '0;
        w_nb = '0;
        for (int i = 0; i < NIB; i++) begin
            if (r_cnt == CW'(i)) begin
                w_na = r_a[i*SLICE_W +: SLICE_W];
                w_nb = r_b[i*SLICE_W +: SLICE_W];
            end
        end
    end

    cla_4 u_slice (
        .i_a  (w_na),
        .i_b  (w_nb),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    // Merge the fresh slice result so the final-pass flags see the whole word.
    always_comb begin
        w_sum_nxt = r_sum;
        for (int i = 0; i < NIB; i++) begin
            if (r_cnt == CW'(i)) begin
                w_sum_nxt[i*SLICE_W +: SLICE_W] = w_s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE:    w_state_nxt = in_valid ? RUN : IDLE;
            RUN:     w_state_nxt = w_last ? DONE : RUN;
            DONE:    w_state_nxt = out_ready ? IDLE : DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in.
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_carry <= sub;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_sum   <= w_sum_nxt;
            r_carry <= w_co;
            if (w_last) begin
                r_cout <= w_co;
                r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[SLICE_W-1] != r_a[WIDTH-1]);
                r_zero <= (w_sum_nxt == '0);
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign c_out     = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_cla_seq16.sv
// Directed bench for cla_seq16: reference results come from plain integer
// arithmetic, are queued at accept and compared when out_valid rises.
module tb_cla_seq16;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         zero;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    exp_t sb[$];
    int   n_asrt = 0;
    int   n_fail = 0;

    cla_seq16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t         e;
        logic [W-1:0] yy;
        logic [W:0]   full;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.v  = (x[W-1] == yy[W-1]) && (e.s[W-1] != x[W-1]);
        e.z  = (e.s == '0);
        return e;
    endfunction

    // Accept one operation, wait for the result, compare; leaves DUT in DONE.
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s);
        int   lat;
        exp_t ev;
        @(negedge clk);
        a = x; b = y; sub = s; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        sb.push_back(model(x, y, s));
        in_valid = 1'b0;
        a = ~x; b = ~y; sub = ~s;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk({tag, " latency"}, lat, 4);
        if (sb.size() > 0) begin
            ev = sb.pop_front();
            chk({tag, " sum"},   {16'h0, sum},   {16'h0, ev.s});
            chk({tag, " c_out"}, {31'h0, c_out}, {31'h0, ev.c});
            chk({tag, " ovf"},   {31'h0, ovf},   {31'h0, ev.v});
            chk({tag, " zero"},  {31'h0, zero},  {31'h0, ev.z});
        end
    endtask

    task automatic release_out(input string tag);
        logic [W-1:0] hold;
        hold = sum;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, " idle in_ready"}, {31'h0, in_ready}, 32'h1);
        chk({tag, " idle out_valid"}, {31'h0, out_valid}, 32'h0);
        chk({tag, " sum kept"}, {16'h0, sum}, {16'h0, hold});
    endtask

    initial begin
        logic [W-1:0] hs;
        logic         hc, hv, hz;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst sum", {16'h0, sum}, 32'h0);
        chk("rst flags", {29'h0, c_out, ovf, zero}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add1234", 16'h1234, 16'h4321, 1'b0);
        chk("add1234 sum const", {16'h0, sum}, 32'h5555);
        release_out("add1234");
        run_op("wrap", 16'hFFFF, 16'h0001, 1'b0);
        chk("wrap zero const", {31'h0, zero}, 32'h1);
        release_out("wrap");
        run_op("povf", 16'h7FFF, 16'h0001, 1'b0);
        release_out("povf");
        run_op("sub5_7", 16'h0005, 16'h0007, 1'b1);
        chk("sub5_7 sum const", {16'h0, sum}, 32'hFFFE);
        release_out("sub5_7");
        run_op("sub8000", 16'h8000, 16'h0001, 1'b1);
        chk("sub8000 ovf const", {31'h0, ovf}, 32'h1);

        // Stall in DONE with noisy inputs: nothing may move or be accepted.
        hs = sum; hc = c_out; hv = ovf; hz = zero;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            a = W'($urandom); b = W'($urandom); sub = ~sub;
            @(posedge clk);
            #1;
            chk("hold out_valid", {31'h0, out_valid}, 32'h1);
            chk("hold in_ready", {31'h0, in_ready}, 32'h0);
            chk("hold sum", {16'h0, sum}, {16'h0, hs});
            chk("hold flags", {29'h0, c_out, ovf, zero}, {29'h0, hc, hv, hz});
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_out("sub8000");

        for (int k = 0; k < 6; k++) begin
            logic [W-1:0] rx, ry;
            logic         rs;
            rx = W'($urandom); ry = W'($urandom); rs = 1'($urandom_range(1, 0));
            run_op("rand", rx, ry, rs);
            release_out("rand");
        end
        run_op("selfsub", 16'hA5A5, 16'hA5A5, 1'b1);
        release_out("selfsub");

        // Reset mid-operation: abandon it, outputs clear without a clock edge.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", {31'h0, out_valid}, 32'h0);
        chk("midrst in_ready", {31'h0, in_ready}, 32'h1);
        chk("midrst sum", {16'h0, sum}, 32'h0);
        chk("midrst flags", {29'h0, c_out, ovf, zero}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst in_ready", {31'h0, in_ready}, 32'h1);
        run_op("postrst", 16'h0001, 16'h0001, 1'b0);
        chk("postrst sum const", {16'h0, sum}, 32'h0002);
        release_out("postrst");

        chk("scoreboard empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
